// File: rtl/canny_pass_sched_pkg.sv
// Shared encodings and defaults for the five-pass edge-pipeline scheduler.
package canny_pass_sched_pkg;

    localparam int CPS_IMG_DIM = 20;
    localparam int CPS_ADDR_W  = 9;
    localparam int KMAX        = 5;
    localparam int H_W         = 3;

    typedef enum logic [2:0] {
        OP_IDLE   = 3'd0,
        OP_MED    = 3'd1,
        OP_GAU    = 3'd2,
        OP_SOBEL  = 3'd3,
        OP_NONMAX = 3'd4,
        OP_HYSTER = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_FLUSH, S_BORDER, S_COMMIT, S_FIN
    } state_t;

    // Window height of the filter that runs for a given pass.
    function automatic logic [H_W-1:0] kernel_size(op_t op);
        return (op == OP_GAU) ? H_W'(5) : H_W'(3);
    endfunction

endpackage

// File: rtl/canny_pass_sched_if.sv
// Scheduler <-> filter/register-file signal bundle.
interface canny_pass_sched_if
    import canny_pass_sched_pkg::*;
#(
    parameter int ADDR_W = CPS_ADDR_W
);
    logic              start;
    op_t               op;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4;
    logic [ADDR_W-1:0] ang_rd_addr;
    logic              mod_clr;
    logic              mod_readable;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              ang_we;
    logic              cp_en;
    logic [ADDR_W-1:0] cp_src, cp_dst;
    logic              commit;
    logic              edge_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, mod_readable,
        output op, rd_valid, rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4,
               ang_rd_addr, mod_clr, wr_en, wr_addr, ang_we, cp_en, cp_src,
               cp_dst, commit, edge_valid, busy, done
    );

    modport slave (
        output start, mod_readable,
        input  op, rd_valid, rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4,
               ang_rd_addr, mod_clr, wr_en, wr_addr, ang_we, cp_en, cp_src,
               cp_dst, commit, edge_valid, busy, done
    );
endinterface

// File: rtl/canny_pass_sched_border_walker.sv
// Raster walk over the temp file that replicates the H-wide border from the
// nearest interior pixel.
module border_walker
    import canny_pass_sched_pkg::*;
#(
    parameter int IMG_DIM = CPS_IMG_DIM,
    parameter int ADDR_W  = CPS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [H_W-1:0]    h,
    output logic              cp_en,
    output logic [ADDR_W-1:0] cp_src,
    output logic [ADDR_W-1:0] cp_dst,
    output logic              last
);
    localparam int CW = $clog2(IMG_DIM);
    localparam logic [CW-1:0]     MAX_C = CW'(IMG_DIM - 1);
    localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(IMG_DIM);

    logic [CW-1:0] y, x, h_c, hi, cy, cx;
    logic          on_edge;

    // start is held for the whole walk; the counters park at (0,0) otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y <= '0;
            x <= '0;
        end else if (!start) begin
            y <= '0;
            x <= '0;
        end else if (x == MAX_C) begin
            x <= '0;
            y <= (y == MAX_C) ? '0 : y + CW'(1);
        end else begin
            x <= x + CW'(1);
        end
    end

    assign h_c     = CW'(h);
    assign hi      = MAX_C - h_c;
    assign on_edge = (y < h_c) || (y > hi) || (x < h_c) || (x > hi);
    assign cy      = (y < h_c) ? h_c : (y > hi) ? hi : y;
    assign cx      = (x < h_c) ? h_c : (x > hi) ? hi : x;

    assign cp_en  = start && on_edge;
    assign cp_dst = cp_en ? ADDR_W'(y) * DIM_A + ADDR_W'(x) : '0;
    assign cp_src = cp_en ? ADDR_W'(cy) * DIM_A + ADDR_W'(cx) : '0;
    assign last   = start && (y == MAX_C) && (x == MAX_C);

endmodule

// File: rtl/canny_pass_sched.sv
// Pass sequencer for median -> gaussian -> sobel -> non-max -> hysteresis over
// the square pixel register file: read windows, temp writes, border fill, commit.
module canny_pass_sched
    import canny_pass_sched_pkg::*;
#(
    parameter int IMG_DIM = CPS_IMG_DIM,
    parameter int ADDR_W  = CPS_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    canny_pass_sched_if.master bus
);
    localparam logic [ADDR_W-1:0] DIM_A  = ADDR_W'(IMG_DIM);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_DIM - 1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    state_t                       state;
    op_t                          op;
    logic [H_W-1:0]               k, h, setup_k;
    logic [ADDR_W-1:0]            r, c, wc, wr_addr;
    logic [ADDR_W-1:0]            k_a, h_a, setup_h, wc_nxt, wc_tgt;
    logic                         rd_valid, counting, walk_run, walk_last;
    logic [KMAX-1:0][ADDR_W-1:0]  rd_addr;

    assign setup_k  = kernel_size(op);
    assign setup_h  = ADDR_W'(setup_k >> 1);
    assign k_a      = ADDR_W'(k);
    assign h_a      = ADDR_W'(h);
    assign rd_valid = (state == S_SCAN);
    assign counting = (state == S_SCAN) || (state == S_DRAIN);
    assign walk_run = (state == S_BORDER);
    // A readable arriving in the cycle the count hits its target still counts.
    assign wc_nxt   = wc + ADDR_W'(bus.mod_readable);
    assign wc_tgt   = DIM_A - k_a + ONE_A;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            op      <= OP_IDLE;
            k       <= '0;
            h       <= '0;
            r       <= '0;
            c       <= '0;
            wc      <= '0;
            wr_addr <= '0;
        end else begin
            if (counting && bus.mod_readable) begin
                wr_addr <= wr_addr + ONE_A;
                wc      <= wc + ONE_A;
            end
            unique case (state)
                S_IDLE: if (bus.start) begin
                    op    <= OP_MED;
                    state <= S_SETUP;
                end
                S_SETUP: begin
                    k       <= setup_k;
                    h       <= setup_k >> 1;
                    r       <= '0;
                    c       <= '0;
                    wc      <= '0;
                    wr_addr <= setup_h * DIM_A + setup_h;
                    state   <= S_SCAN;
                end
                S_SCAN: begin
                    c <= c + ONE_A;
                    if (c == LAST_A) state <= S_DRAIN;
                end
                S_DRAIN: if (wc_nxt >= wc_tgt) begin
                    if (r < DIM_A - k_a)      state <= S_FLUSH;
                    else if (op == OP_HYSTER) state <= S_FIN;
                    else                      state <= S_BORDER;
                end
                S_FLUSH: begin
                    r       <= r + ONE_A;
                    c       <= '0;
                    wc      <= '0;
                    wr_addr <= (r + ONE_A + h_a) * DIM_A + h_a;
                    state   <= S_SCAN;
                end
                S_BORDER: if (walk_last) state <= S_COMMIT;
                S_COMMIT: begin
                    op    <= op_t'(op + 3'd1);
                    state <= S_SETUP;
                end
                S_FIN: begin
                    op    <= OP_IDLE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Rows beyond the active kernel read as address 0.
    for (genvar j = 0; j < KMAX; j++) begin : g_row
        assign rd_addr[j] = (rd_valid && (H_W'(j) < k))
                          ? (r + ADDR_W'(j)) * DIM_A + c : '0;
    end

    border_walker #(
        .IMG_DIM (IMG_DIM),
        .ADDR_W  (ADDR_W)
    ) u_walk (
        .clk    (clk),
        .reset  (reset),
        .start  (walk_run),
        .h      (h),
        .cp_en  (bus.cp_en),
        .cp_src (bus.cp_src),
        .cp_dst (bus.cp_dst),
        .last   (walk_last)
    );

    assign bus.op          = op;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_addr0    = rd_addr[0];
    assign bus.rd_addr1    = rd_addr[1];
    assign bus.rd_addr2    = rd_addr[2];
    assign bus.rd_addr3    = rd_addr[3];
    assign bus.rd_addr4    = rd_addr[4];
    assign bus.ang_rd_addr = rd_valid ? (r + ONE_A) * DIM_A + c : '0;
    assign bus.mod_clr     = (state == S_FLUSH);
    assign bus.wr_en       = counting && bus.mod_readable && (op != OP_HYSTER);
    assign bus.wr_addr     = wr_addr;
    assign bus.ang_we      = bus.wr_en && (op == OP_SOBEL);
    assign bus.commit      = (state == S_COMMIT);
    assign bus.edge_valid  = counting && bus.mod_readable && (op == OP_HYSTER);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_FIN);

endmodule

// File: tb/tb_canny_pass_sched.sv
// Directed bench for canny_pass_sched: full five-pass run logged and checked
// against a vector table, plus reset and mid-pass abort sequences.
`timescale 1ns/1ps
module tb_canny_pass_sched;
    import canny_pass_sched_pkg::*;

    localparam int AW = 9;
    localparam int K_RD = 0, K_WR = 1, K_CPS = 2, K_CPD = 3,
                   K_NRD = 4, K_NWR = 5, K_NCP = 6, K_NCLR = 7;

    typedef struct {
        string name;
        int    kind;
        int    op;
        int    idx;
        int    sub;
        int    exp;
    } vec_t;
    typedef struct {
        int                   op;
        logic [5:0][AW-1:0]   a;
    } rd_t;
    typedef struct {
        int op;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    canny_pass_sched_if #(.ADDR_W(AW)) bus();
    canny_pass_sched dut (.clk(clk), .reset(rst_n), .bus(bus));

    int   checks = 0, errors = 0;
    vec_t vecs[$];
    rd_t  rd_q[$];
    ev_t  wr_q[$];
    ev_t  cp_q[$];
    int   clr_cnt[6] = '{default: 0};
    int   commit_cnt = 0, done_cnt = 0, edge_cnt = 0, ang_cnt = 0, ang_bad = 0;
    int   ncol = 0;
    logic [2:0] hist = '0;
    bit   sent = 1'b0;
    int   base;
    rd_t  rd_e;
    ev_t  ev_e;

    // Filter model: output valid two cycles after each read once K columns are in.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            ncol = 0;
            hist = '0;
        end else begin
            hist = {hist[1:0], bus.rd_valid && (ncol >= ((bus.op == OP_GAU) ? 4 : 2))};
            ncol = bus.rd_valid ? ncol + 1 : 0;
        end
        bus.mod_readable = hist[2];
    end

    always @(negedge clk) if (rst_n) begin
        if (bus.rd_valid) begin
            rd_e.op = int'(bus.op);
            rd_e.a  = {bus.ang_rd_addr, bus.rd_addr4, bus.rd_addr3,
                       bus.rd_addr2, bus.rd_addr1, bus.rd_addr0};
            rd_q.push_back(rd_e);
        end
        if (bus.wr_en) begin
            ev_e.op = int'(bus.op); ev_e.a = int'(bus.wr_addr); ev_e.b = 0;
            wr_q.push_back(ev_e);
        end
        if (bus.cp_en) begin
            ev_e.op = int'(bus.op); ev_e.a = int'(bus.cp_src); ev_e.b = int'(bus.cp_dst);
            cp_q.push_back(ev_e);
        end
        if (bus.ang_we) begin
            ang_cnt++;
            if (bus.op != OP_SOBEL) ang_bad++;
        end
        if (bus.mod_clr)    clr_cnt[int'(bus.op)]++;
        if (bus.commit)     commit_cnt++;
        if (bus.done)       done_cnt++;
        if (bus.edge_valid) edge_cnt++;
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(string nm, int kind, int op, int idx, int sub, int exp);
        vec_t v;
        v.name = nm; v.kind = kind; v.op = op; v.idx = idx; v.sub = sub; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic int lookup(vec_t v);
        int n = 0;
        int r = -1;
        case (v.kind)
            K_RD, K_NRD: foreach (rd_q[i]) if (rd_q[i].op == v.op) begin
                if (n == v.idx) r = int'(rd_q[i].a[v.sub]);
                n++;
            end
            K_WR, K_NWR: foreach (wr_q[i]) if (wr_q[i].op == v.op) begin
                if (n == v.idx) r = wr_q[i].a;
                n++;
            end
            K_CPS, K_CPD, K_NCP: foreach (cp_q[i]) if (cp_q[i].op == v.op) begin
                if (n == v.idx) r = (v.kind == K_CPS) ? cp_q[i].a : cp_q[i].b;
                n++;
            end
            default: r = clr_cnt[v.op];
        endcase
        if (v.kind == K_NRD || v.kind == K_NWR || v.kind == K_NCP) r = n;
        return r;
    endfunction

    initial begin
        rst_n = 1'b1;
        bus.start = 1'b0;

        // name, kind, op, event index, sub-field, expected
        add("med_rd0_c0",   K_RD, 1, 0, 0, 0);
        add("med_rd1_c0",   K_RD, 1, 0, 1, 20);
        add("med_rd2_c0",   K_RD, 1, 0, 2, 40);
        add("med_rd3_zero", K_RD, 1, 0, 3, 0);
        add("med_rd4_zero", K_RD, 1, 0, 4, 0);
        add("med_rd0_c19",  K_RD, 1, 19, 0, 19);
        add("med_rd1_c19",  K_RD, 1, 19, 1, 39);
        add("med_rd2_c19",  K_RD, 1, 19, 2, 59);
        add("med_rd0_band1", K_RD, 1, 20, 0, 20);
        add("med_wr_first", K_WR, 1, 0, 0, 21);
        add("med_wr_17",    K_WR, 1, 17, 0, 38);
        add("med_wr_band1", K_WR, 1, 18, 0, 41);
        add("med_n_rd",     K_NRD, 1, -1, 0, 360);
        add("med_n_wr",     K_NWR, 1, -1, 0, 324);
        add("med_n_clr",    K_NCLR, 1, -1, 0, 17);
        add("med_n_cp",     K_NCP, 1, -1, 0, 76);
        add("med_cp00_src", K_CPS, 1, 0, 0, 21);
        add("med_cp00_dst", K_CPD, 1, 0, 0, 0);
        add("med_cp07_src", K_CPS, 1, 7, 0, 27);
        add("med_cp07_dst", K_CPD, 1, 7, 0, 7);
        add("med_cp119_src", K_CPS, 1, 21, 0, 38);
        add("med_cp119_dst", K_CPD, 1, 21, 0, 39);
        add("med_cp1919_src", K_CPS, 1, 75, 0, 378);
        add("med_cp1919_dst", K_CPD, 1, 75, 0, 399);
        add("gau_rd0_c0",   K_RD, 2, 0, 0, 0);
        add("gau_rd1_c0",   K_RD, 2, 0, 1, 20);
        add("gau_rd2_c0",   K_RD, 2, 0, 2, 40);
        add("gau_rd3_c0",   K_RD, 2, 0, 3, 60);
        add("gau_rd4_c0",   K_RD, 2, 0, 4, 80);
        add("gau_rd4_c19",  K_RD, 2, 19, 4, 99);
        add("gau_wr_first", K_WR, 2, 0, 0, 42);
        add("gau_wr_15",    K_WR, 2, 15, 0, 57);
        add("gau_wr_band1", K_WR, 2, 16, 0, 62);
        add("gau_wr_last",  K_WR, 2, 255, 0, 357);
        add("gau_n_rd",     K_NRD, 2, -1, 0, 320);
        add("gau_n_wr",     K_NWR, 2, -1, 0, 256);
        add("gau_n_clr",    K_NCLR, 2, -1, 0, 15);
        add("gau_n_cp",     K_NCP, 2, -1, 0, 144);
        add("gau_cp00_src", K_CPS, 2, 0, 0, 42);
        add("gau_cp10_src", K_CPS, 2, 20, 0, 42);
        add("gau_cp10_dst", K_CPD, 2, 20, 0, 20);
        add("gau_cp1919_src", K_CPS, 2, 143, 0, 357);
        add("sob_rd3_zero", K_RD, 3, 0, 3, 0);
        add("sob_n_wr",     K_NWR, 3, -1, 0, 324);
        add("sob_cp_last_dst", K_CPD, 3, 75, 0, 399);
        add("nmx_ang_c0",   K_RD, 4, 0, 5, 20);
        add("nmx_ang_b1c1", K_RD, 4, 21, 5, 41);
        add("nmx_n_wr",     K_NWR, 4, -1, 0, 324);
        add("nmx_n_cp",     K_NCP, 4, -1, 0, 76);
        add("hys_n_rd",     K_NRD, 5, -1, 0, 360);
        add("hys_n_wr",     K_NWR, 5, -1, 0, 0);
        add("hys_n_cp",     K_NCP, 5, -1, 0, 0);
        add("hys_n_clr",    K_NCLR, 5, -1, 0, 17);

        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_busy",     int'(bus.busy), 0);
        chk("rst_op",       int'(bus.op), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_rd_addr0", int'(bus.rd_addr0), 0);
        chk("rst_ang_rd",   int'(bus.ang_rd_addr), 0);
        chk("rst_wr_en",    int'(bus.wr_en), 0);
        chk("rst_wr_addr",  int'(bus.wr_addr), 0);
        chk("rst_cp_en",    int'(bus.cp_en), 0);
        chk("rst_cp_src",   int'(bus.cp_src), 0);
        chk("rst_commit",   int'(bus.commit), 0);
        chk("rst_done",     int'(bus.done), 0);
        chk("rst_mod_clr",  int'(bus.mod_clr), 0);

        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", int'(bus.busy), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("setup_op_med", int'(bus.op), 1);
        chk("setup_busy", int'(bus.busy), 1);

        // Run to completion; a start pulse mid-run must be ignored.
        for (int i = 0; i < 30000 && done_cnt == 0; i++) begin
            if (!sent && bus.op == OP_GAU) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                sent = 1'b1;
            end else begin
                tick();
            end
        end
        tick(5);
        chk("run_done_once", done_cnt, 1);
        chk("run_busy_after", int'(bus.busy), 0);
        chk("run_op_after", int'(bus.op), 0);
        chk("run_commits", commit_cnt, 4);
        chk("run_ang_we", ang_cnt, 324);
        chk("run_ang_we_bad_op", ang_bad, 0);
        chk("run_edge_valid", edge_cnt, 324);

        foreach (vecs[i]) chk(vecs[i].name, lookup(vecs[i]), vecs[i].exp);

        // Abort mid-SCAN of the gaussian pass.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5000 && !(bus.op == OP_GAU && bus.rd_valid); i++) tick();
        chk("abort_reached_gau_scan", int'(bus.op == OP_GAU && bus.rd_valid), 1);
        tick(4);
        base = commit_cnt;
        rst_n = 1'b0;
        tick();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_op", int'(bus.op), 0);
        chk("abort_rd_valid", int'(bus.rd_valid), 0);
        rst_n = 1'b1;
        tick(60);
        chk("abort_no_commit", commit_cnt - base, 0);
        chk("abort_stays_idle", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
